// File: rtl/sd_block_sequencer_if.sv
// SPI byte-shifter handshake between the block sequencer (master) and the
// byte shifter (slave). Exactly one exchange can be outstanding at a time.
interface sd_block_sequencer_if;
  logic       sh_start;
  logic [7:0] sh_byte;
  logic       sh_done;
  logic [7:0] sh_rxbyte;

  modport master (output sh_start, output sh_byte, input sh_done, input sh_rxbyte);
  modport slave  (input sh_start, input sh_byte, output sh_done, output sh_rxbyte);
endinterface

// File: rtl/sd_block_sequencer.sv
// SD card SPI-mode block sequencer: drives start-token / data / CRC /
// data-response / write-busy phases of a single block read or write through
// a byte-exchange shifter. All state changes on the falling clock edge.
module sd_block_sequencer #(
  parameter int unsigned TOKEN_LIMIT = 255,
  parameter int unsigned BUSY_LIMIT  = 65535
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_start,
  input  logic                         cmd_write,
  input  logic [9:0]                   cmd_count,
  input  logic                         cmd_abort,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  sd_block_sequencer_if.master         sh,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [4:0]                   resp_code
);

  typedef enum logic [2:0] {
    IDLE,
    TOKEN,
    DATA,
    CRC,
    RESP,
    BUSYWAIT,
    FINISH
  } state_t;

  localparam logic [7:0]  TOKEN_LAST = 8'(TOKEN_LIMIT - 1);
  localparam logic [15:0] BUSY_LAST  = 16'(BUSY_LIMIT - 1);
  localparam logic [7:0]  START_TOK  = 8'hFE;
  localparam logic [7:0]  FILL_BYTE  = 8'hFF;
  localparam logic [4:0]  RESP_OK    = 5'b00101;

  state_t      state;
  logic        is_write;
  logic [9:0]  byte_cnt;
  logic [7:0]  poll_cnt;
  logic [15:0] busy_cnt;
  logic        crc_second;
  logic        in_flight;
  logic        abort_pend;
  logic        abort_req;

  assign busy      = (state != IDLE);
  // A pending abort and a same-cycle abort are handled identically.
  assign abort_req = abort_pend | cmd_abort;

  // Sequencer FSM: one exchange at a time, byte processing before abort.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      byte_cnt    <= '0;
      poll_cnt    <= '0;
      busy_cnt    <= '0;
      crc_second  <= 1'b0;
      in_flight   <= 1'b0;
      abort_pend  <= 1'b0;
      sh.sh_start <= 1'b0;
      sh.sh_byte  <= FILL_BYTE;
      tx_ready    <= 1'b0;
      rx_data     <= FILL_BYTE;
      rx_valid    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      resp_code   <= '0;
    end else begin
      sh.sh_start <= 1'b0;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      done        <= 1'b0;

      if (state != IDLE && state != FINISH && cmd_abort)
        abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (cmd_start) begin
            is_write   <= cmd_write;
            byte_cnt   <= cmd_count;
            poll_cnt   <= '0;
            busy_cnt   <= '0;
            crc_second <= 1'b0;
            abort_pend <= 1'b0;
            err        <= 1'b0;
            resp_code  <= '0;
            state      <= TOKEN;
          end
        end

        FINISH: begin
          done       <= 1'b1;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          if (!in_flight) begin
            if (abort_req) begin
              err   <= 1'b1;
              state <= FINISH;
            end else if (state == DATA && is_write) begin
              if (tx_valid) begin
                sh.sh_start <= 1'b1;
                sh.sh_byte  <= tx_data;
                tx_ready    <= 1'b1;
                in_flight   <= 1'b1;
              end
            end else begin
              sh.sh_start <= 1'b1;
              sh.sh_byte  <= (state == TOKEN && is_write) ? START_TOK : FILL_BYTE;
              in_flight   <= 1'b1;
            end
          end else if (sh.sh_done) begin
            in_flight <= 1'b0;
            case (state)
              TOKEN: begin
                if (is_write || sh.sh_rxbyte == START_TOK) begin
                  state <= (byte_cnt == '0) ? CRC : DATA;
                end else if (poll_cnt == TOKEN_LAST) begin
                  err   <= 1'b1;
                  state <= FINISH;
                end else begin
                  poll_cnt <= poll_cnt + 8'd1;
                end
              end
              DATA: begin
                if (!is_write) begin
                  rx_data  <= sh.sh_rxbyte;
                  rx_valid <= 1'b1;
                end
                byte_cnt <= byte_cnt - 10'd1;
                if (byte_cnt == 10'd1)
                  state <= CRC;
              end
              CRC: begin
                if (crc_second)
                  state <= is_write ? RESP : FINISH;
                else
                  crc_second <= 1'b1;
              end
              RESP: begin
                resp_code <= sh.sh_rxbyte[4:0];
                if (sh.sh_rxbyte[4:0] == RESP_OK) begin
                  state <= BUSYWAIT;
                end else begin
                  err   <= 1'b1;
                  state <= FINISH;
                end
              end
              BUSYWAIT: begin
                if (sh.sh_rxbyte != '0) begin
                  state <= FINISH;
                end else if (busy_cnt == BUSY_LAST) begin
                  err   <= 1'b1;
                  state <= FINISH;
                end else begin
                  busy_cnt <= busy_cnt + 16'd1;
                end
              end
              default: state <= IDLE;
            endcase
            // The completed byte above is still consumed; abort only
            // overrides where the FSM goes next.
            if (abort_req) begin
              err   <= 1'b1;
              state <= FINISH;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sd_block_sequencer.md
SD_BLOCK_SEQUENCER -- requirements
Module: sd_block_sequencer

Interface
REQ-001 SHALL take parameter TOKEN_LIMIT, default 255: maximum 0xFF polls while waiting for the read start token.
REQ-002 SHALL take parameter BUSY_LIMIT, default 65535: maximum polls while waiting for the card to leave write-busy.
REQ-003 SHALL have port clock, input, 1: single system clock; all state changes on its falling edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_start, input, 1: one-cycle request to begin a block operation.
REQ-006 SHALL have port cmd_write, input, 1: 0 = block read, 1 = block write; sampled with cmd_start.
REQ-007 SHALL have port cmd_count, input, 10: number of data bytes; sampled with cmd_start; 0 = skip the data phase.
REQ-008 SHALL have port cmd_abort, input, 1: request early termination.
REQ-009 SHALL have port tx_data, input, 8: write-data byte.
REQ-010 SHALL have port tx_valid, input, 1: tx_data is valid.
REQ-011 SHALL have port tx_ready, output, 1: one-cycle pulse; tx_data has been consumed.
REQ-012 SHALL have port rx_data, output, 8: received data byte.
REQ-013 SHALL have port rx_valid, output, 1: one-cycle pulse; rx_data is valid.
REQ-014 SHALL have port sh_start, output, 1: one-cycle pulse that starts one SPI byte exchange.
REQ-015 SHALL have port sh_byte, output, 8: byte to transmit; held stable from sh_start until sh_done.
REQ-016 SHALL have port sh_done, input, 1: one-cycle pulse; the shifter has finished the exchange.
REQ-017 SHALL have port sh_rxbyte, input, 8: received byte; valid in the sh_done cycle.
REQ-018 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-019 SHALL have port done, output, 1: one-cycle pulse on return to IDLE.
REQ-020 SHALL have port err, output, 1: operation failed (timeout, bad response or abort); held until the next accepted cmd_start.
REQ-021 SHALL have port resp_code, output, 5: write data-response bits [4:0].

Function
REQ-022 SHALL implement states IDLE, TOKEN, DATA, CRC, RESP, BUSYWAIT and FINISH.
REQ-023 In IDLE, a cmd_start SHALL latch cmd_write and cmd_count, clear err and resp_code, and enter TOKEN on the next edge; cmd_start outside IDLE SHALL be ignored.
REQ-024 SHALL keep at most one exchange outstanding; the next sh_start SHALL be issued no earlier than the cycle after sh_done.
REQ-025 Read TOKEN: SHALL send 0xFF and compare each sh_rxbyte with 0xFE:
- match -> DATA;
- any other value -> poll again, incrementing an 8-bit poll counter;
- after TOKEN_LIMIT polls without a match -> err=1, FINISH.
REQ-026 Write TOKEN: SHALL send 0xFE once, then enter DATA.
REQ-027 Read DATA: SHALL send 0xFF per byte; at each sh_done, SHALL set rx_data=sh_rxbyte, pulse rx_valid and decrement the byte counter.
REQ-028 Write DATA: SHALL issue sh_start only while tx_valid=1, with sh_byte=tx_data and a tx_ready pulse in the same cycle; while tx_valid=0 it SHALL stall indefinitely.
REQ-029 DATA SHALL exit to CRC when the byte counter reaches 0; a zero cmd_count SHALL enter CRC directly.
REQ-030 CRC: SHALL send exactly two 0xFF bytes; received bytes SHALL be discarded and rx_valid SHALL stay low.
REQ-031 After CRC, a read SHALL go to FINISH and a write SHALL go to RESP.
REQ-032 RESP: SHALL send 0xFF and latch resp_code=sh_rxbyte[4:0]:
- resp_code 5'b00101 -> BUSYWAIT;
- any other value -> err=1, FINISH.
REQ-033 BUSYWAIT: SHALL send 0xFF until sh_rxbyte != 0x00, then go to FINISH; a 16-bit poll counter reaching BUSY_LIMIT SHALL set err=1 and go to FINISH.
REQ-034 FINISH SHALL last one cycle, pulse done, and return to IDLE.
REQ-035 cmd_abort while busy SHALL:
- let any in-flight exchange complete;
- issue no further sh_start;
- set err=1 and go to FINISH;
- cmd_abort in IDLE SHALL be ignored.
REQ-036 If cmd_abort and sh_done occur in the same cycle, the received byte SHALL still be processed (rx_valid may pulse), then the FSM SHALL go to FINISH.
REQ-037 The 10-bit byte counter SHALL NOT wrap; a count of 1023 SHALL transfer exactly 1023 bytes.

Reset
REQ-038 reset low SHALL immediately force:
- IDLE; all counters to 0;
- sh_start, tx_ready, rx_valid, done, busy and err to 0;
- resp_code 0, rx_data 0xFF, sh_byte 0xFF.
REQ-039 Reset mid-operation SHALL abandon the transfer without a done pulse.
REQ-040 After reset release, the first falling clock edge SHALL be able to accept cmd_start.

Verification
REQ-041 Read, count=4, card returns 0xFF,0xFF,0xFE,0x11,0x22,0x33,0x44,CRC,CRC -> four rx_valid pulses with 0x11..0x44, 9 sh_start, done, err=0.
REQ-042 Read, card never returns 0xFE -> exactly 255 token polls, then done with err=1 and no rx_valid.
REQ-043 Write, count=2, tx 0xAA,0x55 with tx_valid gapped 3 cycles, response 0xE5, then busy 0x00,0x00,0xFF -> sh_byte sequence FE,AA,55,FF,FF,FF,FF,FF,FF; resp_code=5'b00101; err=0.
REQ-044 Write, response 0x0B -> resp_code=5'b01011, err=1, no BUSYWAIT polls.
REQ-045 cmd_abort raised mid-DATA during an exchange -> that sh_done is honoured, no further sh_start, done with err=1; a cmd_start while busy has no effect.
REQ-046 reset asserted during BUSYWAIT -> busy=0 immediately, no done pulse; a new read afterwards completes normally.
